// File: rtl/dsp_read_channel.sv
// Read-side dispatcher for one AXI4 master port: routes AR beats to slave arbiters and returns R bursts in issue order.
// Optional macro DSP_RD_R_SLICE_EN inserts a 2-entry registered skid slice on the R path to the master.
module dsp_read_channel #(
    parameter int SLV_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int TRANS_RD_RESP_W   = 2,
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30
) (
    input  logic                                      ACLK_i,
    input  logic                                      ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]                 m_ARID_i,
    input  logic [ADDR_WIDTH-1:0]                     m_ARADDR_i,
    input  logic [TRANS_BURST_W-1:0]                  m_ARBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]               m_ARLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]              m_ARSIZE_i,
    input  logic                                      m_ARVALID_i,
    output logic                                      m_ARREADY_o,
    output logic [TRANS_MST_ID_W-1:0]                 m_RID_o,
    output logic [DATA_WIDTH-1:0]                     m_RDATA_o,
    output logic [TRANS_RD_RESP_W-1:0]                m_RRESP_o,
    output logic                                      m_RLAST_o,
    output logic                                      m_RVALID_o,
    input  logic                                      m_RREADY_i,
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]         sa_ARID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]             sa_ARADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]          sa_ARBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]       sa_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]      sa_ARSIZE_o,
    output logic [SLV_AMT-1:0]                        sa_ARVALID_o,
    input  logic [SLV_AMT-1:0]                        sa_ARREADY_i,
    output logic [SLV_AMT-1:0]                        sa_AR_outst_full_o,
    input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]         sa_RID_i,
    input  logic [DATA_WIDTH*SLV_AMT-1:0]             sa_RDATA_i,
    input  logic [TRANS_RD_RESP_W*SLV_AMT-1:0]        sa_RRESP_i,
    input  logic [SLV_AMT-1:0]                        sa_RLAST_i,
    input  logic [SLV_AMT-1:0]                        sa_RVALID_i,
    output logic [SLV_AMT-1:0]                        sa_RREADY_o
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int SEL_W = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;

    typedef struct packed {
        logic [TRANS_MST_ID_W-1:0]  id;
        logic [DATA_WIDTH-1:0]      data;
        logic [TRANS_RD_RESP_W-1:0] resp;
        logic                       last;
    } r_beat_t;

    logic [PTR_W:0]          wr_ptr;
    logic [PTR_W:0]          rd_ptr;
    logic [SLV_ID_W-1:0]     fifo_q [OUTSTANDING_AMT];
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [SEL_W-1:0]        ar_sel;
    logic [SLV_ID_W-1:0]     ar_sel_id;
    logic [SLV_AMT-1:0]      ar_match;
    logic                    ar_push;
    logic [SLV_ID_W-1:0]     head_id;
    logic [SLV_AMT-1:0]      head_sel;
    r_beat_t                 mux_beat;
    logic                    mux_rvalid;
    logic                    r_beat_ready;
    logic                    r_pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

    // Out-of-range slave indices match no port, so the AR is never accepted.
    assign ar_sel = m_ARADDR_i[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];

    always_comb begin
        ar_match  = '0;
        ar_sel_id = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (32'(ar_sel) == 32'(k)) begin
                ar_match[k] = 1'b1;
                ar_sel_id   = SLV_ID_W'(k);
            end
        end
    end

    assign m_ARREADY_o  = ARESETn_i & ~fifo_full & (|(ar_match & sa_ARREADY_i));
    assign sa_ARVALID_o = (ARESETn_i && m_ARVALID_i && !fifo_full) ? ar_match : '0;
    assign ar_push      = m_ARVALID_i & m_ARREADY_o;

    assign sa_ARID_o          = ARESETn_i ? {SLV_AMT{m_ARID_i}}    : '0;
    assign sa_ARADDR_o        = ARESETn_i ? {SLV_AMT{m_ARADDR_i}}  : '0;
    assign sa_ARBURST_o       = ARESETn_i ? {SLV_AMT{m_ARBURST_i}} : '0;
    assign sa_ARLEN_o         = ARESETn_i ? {SLV_AMT{m_ARLEN_i}}   : '0;
    assign sa_ARSIZE_o        = ARESETn_i ? {SLV_AMT{m_ARSIZE_i}}  : '0;
    assign sa_AR_outst_full_o = {SLV_AMT{fifo_full}};

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < OUTSTANDING_AMT; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (ar_push) begin
                fifo_q[wr_ptr[PTR_W-1:0]] <= ar_sel_id;
                wr_ptr                    <= wr_ptr + (PTR_W+1)'(1);
            end
            if (r_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Slot 0 is selected while empty so the mux never forwards an unwritten entry.
    assign head_id = fifo_empty ? '0 : fifo_q[rd_ptr[PTR_W-1:0]];

    always_comb begin
        mux_beat   = '0;
        mux_rvalid = 1'b0;
        head_sel   = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (head_id == SLV_ID_W'(k)) begin
                head_sel[k]   = 1'b1;
                mux_beat.id   = sa_RID_i[TRANS_MST_ID_W*k +: TRANS_MST_ID_W];
                mux_beat.data = sa_RDATA_i[DATA_WIDTH*k +: DATA_WIDTH];
                mux_beat.resp = sa_RRESP_i[TRANS_RD_RESP_W*k +: TRANS_RD_RESP_W];
                mux_beat.last = sa_RLAST_i[k];
                mux_rvalid    = sa_RVALID_i[k] & ~fifo_empty;
            end
        end
    end

    assign sa_RREADY_o = (ARESETn_i && !fifo_empty && r_beat_ready) ? head_sel : '0;

`ifdef DSP_RD_R_SLICE_EN
    r_beat_t     slice_q [2];
    logic        slice_wr;
    logic        slice_rd;
    logic [1:0]  slice_cnt;
    logic        slice_full;
    logic        slice_in;
    logic        slice_out;

    assign slice_full   = (slice_cnt == 2'd2);
    assign slice_in     = mux_rvalid & ~slice_full;
    assign slice_out    = (slice_cnt != 2'd0) & m_RREADY_i;
    assign r_beat_ready = ~slice_full;
    // The burst retires from the order FIFO as soon as its last beat is captured.
    assign r_pop        = slice_in & mux_beat.last;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            slice_q[0] <= '0;
            slice_q[1] <= '0;
            slice_wr   <= 1'b0;
            slice_rd   <= 1'b0;
            slice_cnt  <= 2'd0;
        end else begin
            if (slice_in) begin
                slice_q[slice_wr] <= mux_beat;
                slice_wr          <= ~slice_wr;
            end
            if (slice_out) begin
                slice_rd <= ~slice_rd;
            end
            slice_cnt <= slice_cnt + 2'(slice_in) - 2'(slice_out);
        end
    end

    assign m_RVALID_o = (slice_cnt != 2'd0);
    assign m_RID_o    = slice_q[slice_rd].id;
    assign m_RDATA_o  = slice_q[slice_rd].data;
    assign m_RRESP_o  = slice_q[slice_rd].resp;
    assign m_RLAST_o  = slice_q[slice_rd].last;
`else
    assign r_beat_ready = m_RREADY_i;
    assign m_RVALID_o   = ARESETn_i & mux_rvalid;
    assign m_RID_o      = ARESETn_i ? mux_beat.id   : '0;
    assign m_RDATA_o    = ARESETn_i ? mux_beat.data : '0;
    assign m_RRESP_o    = ARESETn_i ? mux_beat.resp : '0;
    assign m_RLAST_o    = ARESETn_i ? mux_beat.last : 1'b0;
    assign r_pop        = m_RVALID_o & m_RREADY_i & m_RLAST_o;
`endif

endmodule
